// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer that shares one combinational ALU between two
// requesters. It holds registered operands stable for an opcode-dependent time and returns a tagged response.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int LAT_FAST = 1,
  parameter int LAT_MUL  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [5:0]       req0_alufn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req1_alufn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_alufn,
  input  logic [WIDTH-1:0] alu_otp,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal
);

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_MUL = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000100;
  localparam logic [5:0] OP_OR  = 6'b000101;
  localparam logic [5:0] OP_XOR = 6'b000110;
  localparam logic [5:0] OP_SLL = 6'b001000;
  localparam logic [5:0] OP_SRL = 6'b001001;

  localparam int LAT_MAX = (LAT_MUL > LAT_FAST) ? LAT_MUL : LAT_FAST;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic [CW-1:0]    cnt;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [5:0]       sel_fn;

  function automatic logic is_legal(input logic [5:0] fn);
    case (fn)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: is_legal = 1'b1;
      default:                                                      is_legal = 1'b0;
    endcase
  endfunction

  // Round robin: a lone requester wins outright, a tie goes to the port not served last.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
    sel_a  = grant ? req1_a     : req0_a;
    sel_b  = grant ? req1_b     : req0_b;
    sel_fn = grant ? req1_alufn : req0_alufn;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready | req1_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_alufn    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_alufn  <= sel_fn;
            rsp_id     <= grant;
            last_grant <= grant;
            if (is_legal(sel_fn)) begin
              cnt   <= (sel_fn == OP_MUL) ? CW'(LAT_MUL - 1) : CW'(LAT_FAST - 1);
              state <= EXEC;
            end else begin
              // Illegal opcodes never touch the ALU result and answer immediately.
              rsp_result   <= '0;
              rsp_zero     <= 1'b1;
              rsp_overflow <= 1'b0;
              rsp_illegal  <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result   <= alu_otp;
            rsp_zero     <= (alu_otp == '0);
            rsp_overflow <= ((alu_alufn == OP_ADD) || (alu_alufn == OP_SUB)) && alu_overflow;
            rsp_illegal  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter: a behavioural ALU closes the loop,
// expected responses are queued at accept time and compared when the response appears.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int LF = 1;
  localparam int LM = 3;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, MUL = 6'b000010;
  localparam logic [5:0] AND = 6'b000100, OR  = 6'b000101, XOR = 6'b000110;
  localparam logic [5:0] SLL = 6'b001000, SRL = 6'b001001, BAD = 6'b000011;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]   req0_alufn, req1_alufn;
  logic [W-1:0] alu_a, alu_b, alu_otp;
  logic [5:0]   alu_alufn;
  logic         alu_overflow;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_illegal;
  logic [W-1:0] rsp_result;
  logic         force_ovf;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         illegal;
  } rsp_t;

  rsp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter #(.WIDTH(W), .LAT_FAST(LF), .LAT_MUL(LM)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_alufn(req0_alufn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_alufn(req1_alufn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_alufn(alu_alufn), .alu_otp(alu_otp), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_calc(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    case (fn)
      ADD:     alu_calc = a + b;
      SUB:     alu_calc = a - b;
      MUL:     alu_calc = a * b;
      AND:     alu_calc = a & b;
      OR:      alu_calc = a | b;
      XOR:     alu_calc = a ^ b;
      SLL:     alu_calc = a << b[4:0];
      SRL:     alu_calc = a >> b[4:0];
      default: alu_calc = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    s = alu_calc(fn, a, b);
    case (fn)
      ADD:     alu_ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      SUB:     alu_ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      default: alu_ovf = 1'b0;
    endcase
  endfunction

  function automatic rsp_t expect_rsp(input logic id, input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    r.id = id;
    if (fn inside {ADD, SUB, MUL, AND, OR, XOR, SLL, SRL}) begin
      r.result  = alu_calc(fn, a, b);
      r.zero    = (r.result == '0);
      r.ovf     = (fn == ADD || fn == SUB) && (alu_ovf(fn, a, b) || force_ovf);
      r.illegal = 1'b0;
    end else begin
      r.result  = '0;
      r.zero    = 1'b1;
      r.ovf     = 1'b0;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    alu_otp      = alu_calc(alu_alufn, alu_a, alu_b);
    alu_overflow = force_ovf | alu_ovf(alu_alufn, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT idle; leaves off one step after the accept edge.
  task automatic issue(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] fn, input bit push);
    if (port == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_alufn = fn;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_alufn = fn;
    end
    #1;
    check(port ? "ready1" : "ready0", port ? req1_ready : req0_ready, 1'b1);
    check("ready_other", port ? req0_ready : req1_ready, 1'b0);
    if (push) sb.push_back(expect_rsp(port, fn, a, b));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Starts in the cycle after the accept edge; waits for the response, compares it, consumes it.
  task automatic collect(input int exp_lat, input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] fn);
    int   n;
    rsp_t e;
    n = 1;
    while (rsp_valid !== 1'b1 && n <= 20) begin
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      check("exec_alufn", alu_alufn, fn);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
    check("resp_readys", {req0_ready, req1_ready}, 2'b00);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_id", rsp_id, e.id);
      check("rsp_result", rsp_result, e.result);
      check("rsp_zero", rsp_zero, e.zero);
      check("rsp_overflow", rsp_overflow, e.ovf);
      check("rsp_illegal", rsp_illegal, e.illegal);
    end
    check("resp_alu_a", alu_a, a);
    @(posedge clk); #1;
    check("rsp_consumed", rsp_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {alu_a, alu_b, alu_alufn}, '0);
    check(tag, {rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_illegal}, '0);
    check(tag, rsp_result, '0);
  endtask

  initial begin
    int n;
    reset = 1'b1; rsp_ready = 1'b1; force_ovf = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_alufn = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_alufn = '0;
    #12;
    check_all_zero("reset_state");
    check("reset_readys", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Basic add on port 0, then a multi-cycle multiply on port 1.
    issue(1'b0, 32'd5, 32'd7, ADD, 1);
    collect(LF + 1, 32'd5, 32'd7, ADD);
    issue(1'b1, 32'd6, 32'd7, MUL, 1);
    collect(LM + 1, 32'd6, 32'd7, MUL);

    // Both ports held valid: grants must alternate 0,1,0,1.
    req0_valid = 1'b1; req0_a = 32'hFFFF_0000; req0_b = 32'hFFFF_0000; req0_alufn = XOR;
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F; req1_alufn = XOR;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", req0_ready, (i % 2) == 0);
      check("rr_ready1", req1_ready, (i % 2) == 1);
      if (i % 2 == 0) sb.push_back(expect_rsp(1'b0, XOR, req0_a, req0_b));
      else            sb.push_back(expect_rsp(1'b1, XOR, req1_a, req1_b));
      @(posedge clk); #1;
      if (i % 2 == 0) collect(LF + 1, 32'hFFFF_0000, 32'hFFFF_0000, XOR);
      else            collect(LF + 1, 32'h1234_5678, 32'h0F0F_0F0F, XOR);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Overflow capture, overflow masking for logic ops, illegal opcode fast path.
    issue(1'b0, 32'h7FFF_FFFF, 32'd1, ADD, 1);
    collect(LF + 1, 32'h7FFF_FFFF, 32'd1, ADD);
    force_ovf = 1'b1;
    issue(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, AND, 1);
    collect(LF + 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, AND);
    force_ovf = 1'b0;
    issue(1'b0, 32'd9, 32'd4, BAD, 1);
    collect(1, 32'd9, 32'd4, BAD);
    issue(1'b1, 32'h8000_0001, 32'd4, SLL, 1);
    collect(LF + 1, 32'h8000_0001, 32'd4, SLL);

    // Back-pressure: response must hold while rsp_ready is low, no new grants.
    rsp_ready = 1'b0;
    issue(1'b0, 32'd10, 32'd3, SUB, 1);
    n = 1;
    while (rsp_valid !== 1'b1 && n <= 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_latency", n, LF + 1);
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_alufn = ADD;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_alufn = OR;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_result", rsp_result, 32'd7);
      check("stall_id", rsp_id, 1'b0);
      check("stall_readys", {req0_ready, req1_ready}, 2'b00);
      check("stall_alu_a", alu_a, 32'd10);
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    collect(1, 32'd10, 32'd3, SUB);

    // Reset during EXEC discards the op and restores port-0 priority.
    issue(1'b1, 32'd6, 32'd7, MUL, 0);
    #1 reset = 1'b1;
    #1;
    check_all_zero("reset_in_exec");
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_ghost_rsp", rsp_valid, 1'b0);
    end
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_alufn = OR;
    issue(1'b0, 32'd100, 32'd23, ADD, 1);
    collect(LF + 1, 32'd100, 32'd23, ADD);

    check("sb_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
